// File: rtl/dpu_simd_seq.sv
// dpu_simd_seq: multi-lane saturating SIMD datapath driven by a programmable slot sequencer.
// Define DPU_SAT_STATUS_EN to build the sticky per-lane saturation status in sat_flag.
module dpu_simd_seq #(
  parameter int NUM_LANES      = 4,
  parameter int BITWIDTH       = 16,
  parameter int FSM_MAX_STATES = 4,
  parameter int DELAY_WIDTH    = 4,
  parameter int ITER_WIDTH     = 8,
  parameter int MODE_WIDTH     = 4,
  parameter int FRAC_BITS      = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_we,
  input  logic [$clog2(FSM_MAX_STATES)-1:0]     cfg_slot,
  input  logic [MODE_WIDTH-1:0]                 cfg_mode,
  input  logic [BITWIDTH-1:0]                   cfg_imm,
  input  logic                                  seq_we,
  input  logic [$clog2(FSM_MAX_STATES)-1:0]     seq_last_slot,
  input  logic [FSM_MAX_STATES*DELAY_WIDTH-1:0] seq_delays,
  input  logic [ITER_WIDTH-1:0]                 seq_iter,
  input  logic                                  activate,
  input  logic                                  in_valid,
  input  logic [NUM_LANES*BITWIDTH-1:0]         in0,
  input  logic [NUM_LANES*BITWIDTH-1:0]         in1,
  output logic [NUM_LANES*BITWIDTH-1:0]         out,
  output logic                                  out_valid,
  output logic                                  busy,
  output logic [$clog2(FSM_MAX_STATES)-1:0]     active_slot,
  output logic [NUM_LANES-1:0]                  sat_flag
);
  localparam int SW = $clog2(FSM_MAX_STATES);
  localparam int BW = BITWIDTH;
  localparam int DW = DELAY_WIDTH;
  localparam int WW = 2*BW+1;
  localparam int LW = NUM_LANES*BW;
  localparam int LAST_MAX = FSM_MAX_STATES-1;
  localparam logic [MODE_WIDTH-1:0] M_ADD  = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] M_SUB  = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] M_MUL  = MODE_WIDTH'(3);
  localparam logic [MODE_WIDTH-1:0] M_MAC  = MODE_WIDTH'(4);
  localparam logic [MODE_WIDTH-1:0] M_ADDI = MODE_WIDTH'(5);
  localparam logic [MODE_WIDTH-1:0] M_MAX  = MODE_WIDTH'(6);
  localparam logic [MODE_WIDTH-1:0] M_MIN  = MODE_WIDTH'(7);
  localparam logic [MODE_WIDTH-1:0] M_CLR  = MODE_WIDTH'(8);
  localparam logic signed [WW-1:0] SMAX = {{(BW+2){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = {{(BW+2){1'b1}}, {(BW-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 r_state;
  logic [MODE_WIDTH-1:0]  r_mode [FSM_MAX_STATES];
  logic [BW-1:0]          r_imm  [FSM_MAX_STATES];
  logic [SW-1:0]          r_last;
  logic [FSM_MAX_STATES*DW-1:0] r_delays;
  logic [ITER_WIDTH-1:0]  r_iter;
  logic [SW-1:0]          r_slot;
  logic [DW-1:0]          r_dwell;
  logic [ITER_WIDTH-1:0]  r_pass;
  logic [LW-1:0]          r_a, r_b, r_acc;
  logic [MODE_WIDTH-1:0]  r_m;
  logic [BW-1:0]          r_i;
  logic                   r_v;
  logic [DW-1:0]          w_dly [FSM_MAX_STATES];
  logic [SW-1:0]          w_nslot, w_last_in;
  logic [DW-1:0]          w_d0;
  logic [ITER_WIDTH-1:0]  w_pass1;
  logic                   w_seq_ok;
  logic signed [BW-1:0]   w_imm;
  logic [LW-1:0]          w_res;
`ifdef DPU_SAT_STATUS_EN
  logic [NUM_LANES-1:0]   w_clamp;
`endif

  for (genvar k = 0; k < FSM_MAX_STATES; k++) begin : g_dly
    assign w_dly[k] = r_delays[k*DW +: DW];
  end

  assign busy        = (r_state == S_RUN);
  assign active_slot = r_slot;
  assign w_seq_ok    = seq_we && (r_state == S_IDLE);
  assign w_nslot     = r_slot + SW'(1);
  assign w_pass1     = r_pass + ITER_WIDTH'(1);
  assign w_last_in   = (32'(seq_last_slot) > LAST_MAX) ? SW'(LAST_MAX) : seq_last_slot;
  // a start issued alongside a sequence write dwells on the freshly written slot-0 delay
  assign w_d0        = w_seq_ok ? seq_delays[DW-1:0] : w_dly[0];
  assign w_imm       = r_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < FSM_MAX_STATES; k++) begin
        r_mode[k] <= '0;
        r_imm[k]  <= '0;
      end
      r_last   <= '0;
      r_delays <= '0;
      r_iter   <= '0;
      r_state  <= S_IDLE;
      r_slot   <= '0;
      r_dwell  <= '0;
      r_pass   <= '0;
    end else begin
      if (cfg_we) begin
        r_mode[cfg_slot] <= cfg_mode;
        r_imm[cfg_slot]  <= cfg_imm;
      end
      if (w_seq_ok) begin
        r_last   <= w_last_in;
        r_delays <= seq_delays;
        r_iter   <= seq_iter;
      end
      if (activate) begin
        r_state <= S_RUN;
        r_slot  <= '0;
        r_dwell <= w_d0;
        r_pass  <= '0;
      end else if (r_state == S_RUN) begin
        if (r_dwell != '0) begin
          r_dwell <= r_dwell - DW'(1);
        end else if (r_slot != r_last) begin
          r_slot  <= w_nslot;
          r_dwell <= w_dly[w_nslot];
        end else begin
          r_pass  <= w_pass1;
          r_slot  <= '0;
          r_dwell <= w_dly[0];
          if (r_iter != '0 && w_pass1 == r_iter) r_state <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_m <= '0;
      r_i <= '0;
      r_v <= 1'b0;
    end else begin
      r_a <= in0;
      r_b <= in1;
      r_m <= r_mode[r_slot];
      r_i <= r_imm[r_slot];
      r_v <= in_valid && (r_state == S_RUN);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [BW-1:0]   a, b, c;
    logic signed [2*BW-1:0] p;
    logic signed [WW-1:0]   r;
    assign a = r_a[i*BW +: BW];
    assign b = r_b[i*BW +: BW];
    assign c = r_acc[i*BW +: BW];
    assign p = ((2*BW)'(a) * (2*BW)'(b)) >>> FRAC_BITS;
    // every mode is evaluated at full width so one clamp covers all of them
    assign r = (r_m == M_ADD)  ? WW'(a) + WW'(b)
             : (r_m == M_SUB)  ? WW'(a) - WW'(b)
             : (r_m == M_MUL)  ? WW'(p)
             : (r_m == M_MAC)  ? WW'(p) + WW'(c)
             : (r_m == M_ADDI) ? WW'(a) + WW'(w_imm)
             : (r_m == M_MAX)  ? WW'((a > b) ? a : b)
             : (r_m == M_MIN)  ? WW'((a < b) ? a : b)
             : '0;
    assign w_res[i*BW +: BW] = (r > SMAX) ? SMAX[BW-1:0] : (r < SMIN) ? SMIN[BW-1:0] : r[BW-1:0];
`ifdef DPU_SAT_STATUS_EN
    assign w_clamp[i] = (r > SMAX) || (r < SMIN);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      r_acc     <= '0;
    end else begin
      out_valid <= r_v;
      if (r_v) out <= w_res;
      if (activate) r_acc <= '0;
      else if (r_v && (r_m == M_MAC || r_m == M_CLR)) r_acc <= w_res;
    end
  end

`ifdef DPU_SAT_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || activate) sat_flag <= '0;
    else if (r_v) sat_flag <= sat_flag | w_clamp;
  end
`else
  assign sat_flag = '0;
`endif
endmodule

// File: doc/dpu_simd_seq.md
Name: dpu_simd_seq

Overview:
- Next-generation datapath unit for the resource fabric.
- Generalises the single-lane, fixed-16-bit DPU in three ways:
  - NUM_LANES parallel signed lanes of parametrised width.
  - A configurable slot sequencer with a programmable slot count, per-slot dwell and an iteration count.
  - An extended mode set: SUB, ADD_IMM, MAX, MIN, CLR.
- Sits between the word/bulk data ports and the cell switchbox. Driven by an instruction decoder that writes the slot and sequence configuration.

Parameters:
- NUM_LANES, 4, parallel lanes sharing one mode/sequence.
- BITWIDTH, 16, signed width per lane.
- FSM_MAX_STATES, 4, number of mode/immediate slots.
- DELAY_WIDTH, 4, per-slot dwell counter width.
- ITER_WIDTH, 8, pass counter width.
- MODE_WIDTH, 4, mode field width.
- FRAC_BITS, 0, fixed-point fraction bits applied to MUL/MAC products.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  slot table write strobe
- cfg_slot  in  $clog2(FSM_MAX_STATES)  slot index to write
- cfg_mode  in  MODE_WIDTH  mode for the slot
- cfg_imm  in  BITWIDTH  signed immediate for the slot
- seq_we  in  1  sequence config write strobe
- seq_last_slot  in  $clog2(FSM_MAX_STATES)  index of last slot in a pass
- seq_delays  in  FSM_MAX_STATES*DELAY_WIDTH  dwell per slot; slot k occupies bits [k*DELAY_WIDTH +: DELAY_WIDTH]
- seq_iter  in  ITER_WIDTH  pass count; 0 = run until restart/reset
- activate  in  1  start/restart pulse
- in_valid  in  1  operand valid
- in0, in1  in  NUM_LANES*BITWIDTH  lane operands; lane i at [i*BITWIDTH +: BITWIDTH]
- out  out  NUM_LANES*BITWIDTH  lane results
- out_valid  out  1  result valid
- busy  out  1  sequencer in RUN
- active_slot  out  $clog2(FSM_MAX_STATES)  current slot
- sat_flag  out  NUM_LANES  sticky saturation status (see Optional Feature)

Behaviour:
- Reset: synchronous, active-low, dominant over every other input.
  - Zeroes: slot table, sequence config, sequencer (IDLE, slot 0, counters 0), accumulators, pipeline registers, out, out_valid, busy, active_slot, sat_flag.
- Writes:
  - cfg_we takes effect the next cycle in IDLE or RUN. A write to the active slot changes the mode from the next cycle.
  - seq_we is accepted only in IDLE and ignored in RUN.
  - Simultaneous cfg_we and activate: the write lands first, activate sees the new table.
- Sequencer states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - Transitions:
    - activate in IDLE or RUN -> RUN next cycle; slot=0, dwell=delay[0], pass=0, accumulators cleared.
    - In RUN with dwell != 0: dwell decrements.
    - In RUN with dwell == 0 and slot != seq_last_slot: slot+1, dwell=delay[slot+1].
    - In RUN with dwell == 0 and slot == seq_last_slot: pass+1. If seq_iter != 0 and pass+1 == seq_iter -> IDLE, slot=0. Otherwise slot=0, dwell=delay[0].
  - Slot k therefore occupies delay[k]+1 cycles.
  - seq_last_slot >= FSM_MAX_STATES is treated as FSM_MAX_STATES-1.
- Pipeline, latency 2:
  - Stage 1 registers in0, in1, the mode and immediate of the active slot, and v = in_valid & busy.
  - Stage 2 computes and registers out; out_valid = stage-1 v.
  - in_valid in IDLE is dropped. Samples already in stage 1 complete after RUN->IDLE.
- Modes (per lane, signed):
  - 0 NOP: out=0.
  - 1 ADD: in0+in1.
  - 2 SUB: in0-in1.
  - 3 MUL: (in0*in1)>>>FRAC_BITS.
  - 4 MAC: acc += (in0*in1)>>>FRAC_BITS; out = new acc.
  - 5 ADD_IMM: in0+imm.
  - 6 MAX: max(in0,in1).
  - 7 MIN: min(in0,in1).
  - 8 CLR: acc=0, out=0.
  - Others: behave as NOP.
- Arithmetic widths:
  - ADD/SUB/ADD_IMM use BITWIDTH+1 bits.
  - Products use 2*BITWIDTH bits, arithmetic shift, then the MAC add at 2*BITWIDTH+1.
  - All results saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
  - The accumulator holds the saturated value.
- Accumulator updates only on a valid stage-2 MAC or CLR. It holds in all other modes and in IDLE.

Optional Feature:
- Macro: DPU_SAT_STATUS_EN.
- Defined:
  - sat_flag[i] sets when lane i clamps on a valid stage-2 result.
  - Sticky; cleared on activate or reset.
  - Set and clear in the same cycle: clear wins.
- Undefined: sat_flag is tied to 0 and no status logic is built.

Test Plan:
- ADD saturation (lane 0): slot0 ADD, last_slot 0, delays 0, iter 4, activate; in_valid with in0=0x7000, in1=0x2000 -> out lane0=0x7FFF 2 cycles later; sat_flag[0]=1 if DPU_SAT_STATUS_EN, else 0.
- MAC run: slot0 MAC, iter 0, activate; 4 valid cycles with in0=3, in1=2 on all lanes -> outs 6, 12, 18, 24; then CLR slot write, next valid -> out 0.
- Slot timing: slot0 ADD delay 1, slot1 SUB delay 0, last_slot 1, iter 2 -> active_slot sequence 0,0,1,0,0,1 then busy=0; continuous in_valid gives out_valid exactly 6 times.
- FRAC_BITS=8 MUL: in0=0x0180 (1.5), in1=0x0200 (2.0) -> out=0x0300; in0=0x8000, in1=0x8000 -> out=0x7FFF.
- Restart and seq_we: activate mid-pass at slot 1 of 3 -> next cycle slot=0, accumulators 0, pass=0; seq_we during RUN ignored (last_slot unchanged).
- Reset mid-run: rst_n low 1 cycle during MAC with acc=24 -> next cycle busy=0, out=0, out_valid=0, acc=0, slot table zeroed.
